// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: inEXE bit positions, ALUOp codes and funct codes.
package execute_pkg;

  localparam int unsigned ExeRegDst  = 3;
  localparam int unsigned ExeAluOpHi = 2;
  localparam int unsigned ExeAluOpLo = 1;
  localparam int unsigned ExeAluSrc  = 0;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10,
    AluOpOri   = 2'b11
  } alu_op_e;

  localparam logic [5:0] FunctSll  = 6'h00;
  localparam logic [5:0] FunctSrl  = 6'h02;
  localparam logic [5:0] FunctSra  = 6'h03;
  localparam logic [5:0] FunctSllv = 6'h04;
  localparam logic [5:0] FunctSrlv = 6'h06;
  localparam logic [5:0] FunctSrav = 6'h07;
  localparam logic [5:0] FunctAdd  = 6'h20;
  localparam logic [5:0] FunctAddu = 6'h21;
  localparam logic [5:0] FunctSub  = 6'h22;
  localparam logic [5:0] FunctSubu = 6'h23;
  localparam logic [5:0] FunctAnd  = 6'h24;
  localparam logic [5:0] FunctOr   = 6'h25;
  localparam logic [5:0] FunctXor  = 6'h26;
  localparam logic [5:0] FunctNor  = 6'h27;
  localparam logic [5:0] FunctSlt  = 6'h2A;
  localparam logic [5:0] FunctSltu = 6'h2B;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the execute stage. Shift functs exist only when EXECUTE_SHIFT_EN
// is defined; otherwise they fall through to the unlisted-funct result of 0.
module execute_alu
  import execute_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_op_e           alu_op,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] funct_result;

  always_comb begin
    funct_result = '0;
    case (funct)
      FunctAdd, FunctAddu: funct_result = a + b;
      FunctSub, FunctSubu: funct_result = a - b;
      FunctAnd:            funct_result = a & b;
      FunctOr:             funct_result = a | b;
      FunctXor:            funct_result = a ^ b;
      FunctNor:            funct_result = ~(a | b);
      FunctSlt:            funct_result = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
      FunctSltu:           funct_result = {{(DATA_W-1){1'b0}}, a < b};
`ifdef EXECUTE_SHIFT_EN
      FunctSll:            funct_result = b << shamt;
      FunctSrl:            funct_result = b >> shamt;
      FunctSra:            funct_result = $unsigned($signed(b) >>> shamt);
      FunctSllv:           funct_result = b << a[4:0];
      FunctSrlv:           funct_result = b >> a[4:0];
      FunctSrav:           funct_result = $unsigned($signed(b) >>> a[4:0]);
`endif
      default:             funct_result = '0;
    endcase
  end

`ifndef EXECUTE_SHIFT_EN
  // shamt only feeds the shifter
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  always_comb begin
    result = '0;
    unique case (alu_op)
      AluOpAdd:   result = a + b;
      AluOpSub:   result = a - b;
      AluOpOri:   result = a | {{(DATA_W-16){1'b0}}, b[15:0]};
      AluOpFunct: result = funct_result;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// Execute pipeline stage: operand muxing, ALU, branch target and destination register select,
// all registered with one cycle latency. Optional shifts via EXECUTE_SHIFT_EN.
module execute
  import execute_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        inWB,
  input  logic [2:0]        inMEM,
  input  logic [3:0]        inEXE,
  input  logic [DATA_W-1:0] inInstructionAddress,
  input  logic [DATA_W-1:0] inRegA,
  input  logic [DATA_W-1:0] inRegB,
  input  logic [DATA_W-1:0] inInstruction_ls,
  input  logic [4:0]        inLD_rt,
  input  logic [4:0]        inRT_rd,
  output logic [1:0]        outWB,
  output logic [2:0]        outMEM,
  output logic [DATA_W-1:0] outPCJump,
  output logic [DATA_W-1:0] outALUResult,
  output logic              outALUZero,
  output logic [DATA_W-1:0] outRegB,
  output logic [4:0]        outRegF_wreg
);

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] pc_jump;
  logic [4:0]        wreg;
  alu_op_e           alu_op;

  assign alu_op  = alu_op_e'(inEXE[ExeAluOpHi:ExeAluOpLo]);
  assign alu_b   = inEXE[ExeAluSrc] ? inInstruction_ls : inRegB;
  assign wreg    = inEXE[ExeRegDst] ? inRT_rd : inLD_rt;
  assign pc_jump = inInstructionAddress + (inInstruction_ls << 2);

  execute_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .alu_op (alu_op),
    .funct  (inInstruction_ls[5:0]),
    .shamt  (inInstruction_ls[10:6]),
    .a      (inRegA),
    .b      (alu_b),
    .result (alu_result)
  );

  // Zero flag is its own register so it reads 0 while reset holds, not 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outWB        <= '0;
      outMEM       <= '0;
      outPCJump    <= '0;
      outALUResult <= '0;
      outALUZero   <= 1'b0;
      outRegB      <= '0;
      outRegF_wreg <= '0;
    end else begin
      outWB        <= inWB;
      outMEM       <= inMEM;
      outPCJump    <= pc_jump;
      outALUResult <= alu_result;
      outALUZero   <= (alu_result == '0);
      outRegB      <= inRegB;
      outRegF_wreg <= wreg;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: directed cases plus random transactions against a
// behavioural model; a monitor compares registered outputs one cycle after each issue.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  inWB = '0;
  logic [2:0]  inMEM = '0;
  logic [3:0]  inEXE = '0;
  logic [31:0] inInstructionAddress = '0;
  logic [31:0] inRegA = '0;
  logic [31:0] inRegB = '0;
  logic [31:0] inInstruction_ls = '0;
  logic [4:0]  inLD_rt = '0;
  logic [4:0]  inRT_rd = '0;
  logic [1:0]  outWB;
  logic [2:0]  outMEM;
  logic [31:0] outPCJump;
  logic [31:0] outALUResult;
  logic        outALUZero;
  logic [31:0] outRegB;
  logic [4:0]  outRegF_wreg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  mem;
    logic [31:0] pcj;
    logic [31:0] res;
    logic        zero;
    logic [31:0] regb;
    logic [4:0]  wreg;
  } exp_t;

  exp_t exp_q[$];

  execute #(
    .DATA_W (32)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .inWB                 (inWB),
    .inMEM                (inMEM),
    .inEXE                (inEXE),
    .inInstructionAddress (inInstructionAddress),
    .inRegA               (inRegA),
    .inRegB               (inRegB),
    .inInstruction_ls     (inInstruction_ls),
    .inLD_rt              (inLD_rt),
    .inRT_rd              (inRT_rd),
    .outWB                (outWB),
    .outMEM               (outMEM),
    .outPCJump            (outPCJump),
    .outALUResult         (outALUResult),
    .outALUZero           (outALUZero),
    .outRegB              (outRegB),
    .outRegF_wreg         (outRegF_wreg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference ALU written straight from the instruction-set rules.
  function automatic logic [31:0] ref_alu(input logic [3:0] exe, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [5:0]  fn;
    int unsigned sh;
    logic [63:0] wide;
    fn = b[5:0];
    sh = 0;
    wide = '0;
    case (exe[2:1])
      2'b00: return a + b;
      2'b01: return a - b;
      2'b11: return a | (b & 32'h0000_FFFF);
      default: ;
    endcase
    // in R-type, funct/shamt come from the immediate, which is not B when ALUSrc=0
    return 32'h0;
  endfunction

  function automatic logic [31:0] ref_rtype(input logic [31:0] imm, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [5:0]  fn;
    int unsigned sh;
    logic [63:0] wide;
    fn = imm[5:0];
    sh = imm[10:6];
    wide = '0;
    case (fn)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6'h2B: return ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
`ifdef EXECUTE_SHIFT_EN
      6'h00: return b << sh;
      6'h02: return b >> sh;
      6'h03: begin wide = {{32{b[31]}}, b} >> sh; return wide[31:0]; end
      6'h04: return b << a[4:0];
      6'h06: return b >> a[4:0];
      6'h07: begin wide = {{32{b[31]}}, b} >> a[4:0]; return wide[31:0]; end
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_now(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                           input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
    exp_t e;
    logic [31:0] opb;
    inWB = wb; inMEM = mem; inEXE = exe; inInstructionAddress = pc;
    inRegA = a; inRegB = b; inInstruction_ls = imm; inLD_rt = rt; inRT_rd = rd;
    opb = exe[0] ? imm : b;
    e.wb = wb;
    e.mem = mem;
    e.regb = b;
    e.pcj = pc + imm * 32'd4;
    e.wreg = exe[3] ? rd : rt;
    e.res = (exe[2:1] == 2'b10) ? ref_rtype(imm, a, opb) : ref_alu(exe, a, opb);
    e.zero = (e.res == 32'h0);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] exe,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rt, input logic [4:0] rd);
    @(negedge clk);
    drive_now(wb, mem, exe, pc, a, b, imm, rt, rd);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},   {30'b0, outWB}, 32'h0);
    check({tag, "_mem"},  {29'b0, outMEM}, 32'h0);
    check({tag, "_pcj"},  outPCJump, 32'h0);
    check({tag, "_res"},  outALUResult, 32'h0);
    check({tag, "_zero"}, {31'b0, outALUZero}, 32'h0);
    check({tag, "_regb"}, outRegB, 32'h0);
    check({tag, "_wreg"}, {27'b0, outRegF_wreg}, 32'h0);
  endtask

  // Monitor: one registered result per issued transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wb",   {30'b0, outWB}, {30'b0, e.wb});
        check("mem",  {29'b0, outMEM}, {29'b0, e.mem});
        check("pcjump", outPCJump, e.pcj);
        check("result", outALUResult, e.res);
        check("zero", {31'b0, outALUZero}, {31'b0, e.zero});
        check("regb", outRegB, e.regb);
        check("wreg", {27'b0, outRegF_wreg}, {27'b0, e.wreg});
      end
    end
  end

  initial begin
    logic [5:0]  functs [0:15];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [3:0]  exe;
    functs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    #1;
    check_all_zero("reset_init");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // first edge after reset release captures these inputs
    drive_now(2'b01, 3'b010, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd2, 5'd3);
    drive(2'b10, 3'b001, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 5'd4, 5'd5);
    drive(2'b11, 3'b101, 4'b0001, 32'h200, 32'h1000, 32'hCAFE_F00D, 32'hFFFF_FFFC, 5'd9, 5'd1);
    drive(2'b00, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, 5'd0, 5'd8);
    drive(2'b00, 3'b000, 4'b1100, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2B, 5'd0, 5'd8);
    drive(2'b01, 3'b100, 4'b1100, 32'h0, 32'h0, 32'h8000_0000, 32'h103, 5'd0, 5'd10);
    drive(2'b01, 3'b100, 4'b0110, 32'h0, 32'hF0F0_0000, 32'h0, 32'hFFFF_8001, 5'd6, 5'd7);
    drive(2'b01, 3'b100, 4'b1100, 32'h0, 32'h1, 32'h2, 32'h3F, 5'd6, 5'd7);

    for (int i = 0; i < 300; i++) begin
      a   = $urandom;
      b   = ($urandom_range(0, 5) == 0) ? a : $urandom;
      imm[15:0] = {5'($urandom), 5'($urandom), functs[$urandom_range(0, 15)]};
      if ($urandom_range(0, 7) == 0) imm[5:0] = 6'($urandom);
      imm[31:16] = {16{imm[15]}};
      exe = 4'($urandom);
      drive(2'($urandom), 3'($urandom), exe, $urandom, a, b, imm, 5'($urandom), 5'($urandom));
    end

    // Async reset mid-cycle after a transaction left nonzero outputs.
    drive(2'b11, 3'b111, 4'b0000, 32'h40, 32'h11, 32'h22, 32'h8, 5'd31, 5'd30);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    rst = 1'b0;
    drive_now(2'b10, 3'b011, 4'b1101, 32'h80, 32'h7, 32'h9, 32'h3, 5'd12, 5'd13);
    @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
